ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, edge-counter and result width.
REQ-002 SHALL have parameter WIN_W, default 16, measurement-window length width.
REQ-003 SHALL have parameter SETTLE_CYC, default 4, settle cycles between oscillator enable and counting start; legal range is 3 or more.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic rises on it.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, measurement request, sampled only in IDLE.
REQ-007 SHALL have port win_len, input, WIN_W, window length in clk cycles, latched when start is accepted.
REQ-008 SHALL have port ro_in, input, 1, asynchronous output of the 7-stage ring oscillator.
REQ-009 SHALL have port ro_enable, output, 1, drives the ring oscillator's enable input.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port count, output, CNT_W, measured rising-edge count.
REQ-012 SHALL have port count_valid, output, 1, result-valid flag.
REQ-013 SHALL have port count_ready, input, 1, result consumer ready.
REQ-014 SHALL have port count_sat, output, 1, set when the counter saturated during the window.

Function
REQ-015 SHALL implement the FSM states IDLE, SETTLE, MEASURE and DONE.
REQ-016 In IDLE, start=1 SHALL latch win_len, clear count and count_sat, and move to SETTLE on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-017 SHALL stay in SETTLE for exactly SETTLE_CYC cycles, then go to MEASURE; if the latched win_len is 0, it SHALL go directly to DONE with count=0.
REQ-018 SHALL stay in MEASURE for exactly the latched win_len cycles, then go to DONE.
REQ-019 In DONE, count_valid SHALL be 1; the FSM SHALL return to IDLE on the cycle after count_valid and count_ready are both 1.
REQ-020 While count_valid=1, count and count_sat SHALL stay stable.
REQ-021 ro_enable SHALL be a registered output that is 1 only in SETTLE and MEASURE.
REQ-022 ro_in SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is synchronized=1 AND history=0.
REQ-023 Each detected rising edge in a MEASURE cycle SHALL add 1 to count; edges detected in any other state SHALL be ignored.
REQ-024 Latency SHALL be: start accepted at edge T, count_valid=1 from edge T+1+SETTLE_CYC+win_len (T+1+SETTLE_CYC when win_len=0).
REQ-025 start SHALL be ignored while busy=1, with no queuing.
REQ-026 Exact counts SHALL be guaranteed only for ro_in rising-edge spacing of at least 2 clk cycles; faster input SHALL alias without error indication.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, ro_enable=0, busy=0, count=0, count_valid=0, count_sat=0 and all synchronizer flops=0, including mid-SETTLE, MEASURE or DONE.
REQ-028 The first start SHALL be accepted on the first clk edge after rst_n deasserts.

Configuration
REQ-029 With RO_CNT_SATURATE_EN defined, count SHALL hold at 2^CNT_W-1 once reached, further edges are discarded, and count_sat SHALL be set and held until the next accepted start.
REQ-030 Without RO_CNT_SATURATE_EN, count SHALL wrap modulo 2^CNT_W, and count_sat SHALL be constant 0.

Verification
REQ-031 Nominal: SETTLE_CYC=4, win_len=64, ro_in period 8 clk, count_ready=1 -> count=8, count_valid=1 at T+69 for exactly 1 cycle, ro_enable=1 for exactly 68 cycles.
REQ-032 Zero window: win_len=0 -> count=0, count_valid=1 at T+5, ro_enable=1 for exactly 4 cycles.
REQ-033 Backpressure: count_ready=0 for 10 cycles in DONE, with start pulsed -> count_valid, count and busy stay stable, start is ignored, and IDLE is reached on the edge after count_ready=1.
REQ-034 Saturation: CNT_W=4, win_len=256, ro_in period 4 -> with RO_CNT_SATURATE_EN, count=15 and count_sat=1; without it, count=0 (64 mod 16) and count_sat=0.
REQ-035 Reset mid-MEASURE: rst_n=0 at cycle 20 of the window -> ro_enable=0 and busy=0 without a clk edge; a new start then gives a correct count from zero.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized ro_in rising edges over a programmable clk window.
// Optional build macro RO_CNT_SATURATE_EN makes the counter saturate and raise count_sat instead of wrapping.
module ro_freq_meter #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_enable,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             count_sat
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [WIN_W-1:0]   win_q;
  logic               sync1;
  logic               sync2;
  logic               hist;
  logic               rise;

`ifdef RO_CNT_SATURATE_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);
`endif

  // ro_in is asynchronous: two flops to resolve metastability, a third to find the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      win_q       <= '0;
      ro_enable   <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      count_sat   <= 1'b0;
    end else begin
      // Enable trails the state by one cycle so it covers SETTLE_CYC + win_len cycles.
      ro_enable <= (state == SETTLE) || (state == MEASURE);
      case (state)
        IDLE: begin
          if (start) begin
            win_q     <= win_len;
            count     <= '0;
            count_sat <= 1'b0;
            timer     <= TMR_W'(SETTLE_CYC - 1);
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            if (win_q == '0) begin
              state <= DONE;
            end else begin
              timer <= TMR_W'(win_q) - TMR_W'(1);
              state <= MEASURE;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
`ifdef RO_CNT_SATURATE_EN
            if (count != CNT_MAX) count <= count + CNT_W'(1);
            if (count >= CNT_NEAR) count_sat <= 1'b1;
`else
            count <= count + CNT_W'(1);
`endif
          end
          if (timer == '0) begin
            state <= DONE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        DONE: begin
          if (count_valid && count_ready) begin
            count_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            count_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a default 16-bit instance and a 4-bit instance share all inputs.
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        ro_in = 1'b0;
  logic        count_ready = 1'b1;

  logic        ro_enable, busy, count_valid, count_sat;
  logic [15:0] count;
  logic        ro_enable_s, busy_s, count_valid_s, count_sat_s;
  logic [3:0]  count_s;

  int n_tests = 0;
  int n_fail  = 0;
  int ro_per  = 0;
  int ph      = 0;

  ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .ro_in(ro_in),
    .ro_enable(ro_enable), .busy(busy), .count(count), .count_valid(count_valid),
    .count_ready(count_ready), .count_sat(count_sat)
  );

  ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .ro_in(ro_in),
    .ro_enable(ro_enable_s), .busy(busy_s), .count(count_s), .count_valid(count_valid_s),
    .count_ready(count_ready), .count_sat(count_sat_s)
  );

  always #5 clk = ~clk;

  // Oscillator model: one rising edge every ro_per clk cycles, off when ro_per is 0.
  always @(negedge clk) begin
    if (ro_per == 0) begin
      ph    = 0;
      ro_in = 1'b0;
    end else begin
      ph    = (ph + 1) % ro_per;
      ro_in = (ph < ro_per / 2);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launches one measurement and reports latency from the accepting edge, enable cycles and results.
  task automatic run_meas(input int w, input int per, input bit rel_rst,
                          output int lat, output int en, output int vcyc,
                          output int cnt, output int sat,
                          output int lat_s, output int cnt_s, output int sat_s);
    lat = 0; en = 0; vcyc = 0; cnt = -1; sat = -1;
    lat_s = 0; cnt_s = -1; sat_s = -1;
    @(negedge clk);
    ro_per  = per;
    if (rel_rst) rst_n = 1'b1;
    start   = 1'b1;
    win_len = w[15:0];
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      if (ro_enable) en++;
      if (count_valid) begin
        vcyc++;
        if (lat == 0) begin
          lat = k; cnt = int'(count); sat = int'(count_sat);
        end
      end
      if (count_valid_s && lat_s == 0) begin
        lat_s = k; cnt_s = int'(count_s); sat_s = int'(count_sat_s);
      end
      if (lat != 0 && lat_s != 0 && k >= lat + 3) break;
    end
  endtask

  initial begin
    int lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s;
    bit stable;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ro_enable", ro_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_count_sat", count_sat, 0);

    // Nominal, with start presented on the first edge after reset release.
    run_meas(64, 8, 1'b1, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("nom_latency", lat, 69);
    chk("nom_enable_cycles", en, 68);
    chk("nom_valid_cycles", vcyc, 1);
    chk("nom_count", cnt, 8);
    chk("nom_sat", sat, 0);
    chk("nom_count_small", cnt_s, 8);
    chk("nom_busy_after", busy, 0);

    run_meas(40, 5, 1'b0, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("p5_latency", lat, 45);
    chk("p5_count", cnt, 8);
    chk("p5_enable_cycles", en, 44);

    run_meas(0, 8, 1'b0, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("zero_latency", lat, 5);
    chk("zero_enable_cycles", en, 4);
    chk("zero_count", cnt, 0);
    chk("zero_valid_cycles", vcyc, 1);

    run_meas(1, 0, 1'b0, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("win1_latency", lat, 6);
    chk("win1_count", cnt, 0);

    run_meas(256, 4, 1'b0, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("sat_latency", lat_s, 261);
    chk("sat_wide_count", cnt, 64);
    chk("sat_wide_flag", sat, 0);
`ifdef RO_CNT_SATURATE_EN
    chk("sat_count", cnt_s, 15);
    chk("sat_flag", sat_s, 1);
`else
    chk("sat_count", cnt_s, 0);
    chk("sat_flag", sat_s, 0);
`endif

    // Backpressure: result held in DONE while count_ready is low, start pulses ignored.
    count_ready = 1'b0;
    run_meas(16, 8, 1'b0, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("bp_latency", lat, 21);
    chk("bp_count", cnt, 2);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start   = (k == 3 || k == 4);
      win_len = 16'd5;
      @(posedge clk);
      #1;
      if (!count_valid || count != 16'd2 || !busy) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    @(negedge clk);
    start = 1'b0;
    count_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", count_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_queued_start", busy, 0);

    // Reset at cycle 20 of the measurement window, between clock edges.
    @(negedge clk);
    ro_per = 8; start = 1'b1; win_len = 16'd64;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (24) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ro_enable", ro_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", count_valid, 0);
    run_meas(64, 8, 1'b1, lat, en, vcyc, cnt, sat, lat_s, cnt_s, sat_s);
    chk("post_rst_latency", lat, 69);
    chk("post_rst_count", cnt, 8);
    chk("post_rst_enable_cycles", en, 68);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
